// File: rtl/serial_pkg.sv
// Shared serial-link definitions: frame bit values, bit order and receiver state encoding.
// Used by both the transmitter and the receiver so the two ends agree on the frame format.
package serial_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 32;
    localparam int DEFAULT_CLKS_PER_BIT = 2;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Mid-bit offset used to centre the start-bit sample.
    function automatic int half_period(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Resets to a configurable value so an idle serial line never looks like a start bit.
module bit_sync
    import serial_pkg::*;
#(
    parameter logic RESET_VAL = LINE_IDLE
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// Oversampling serial frame receiver: start bit, DATA_WIDTH data bits, stop bit.
// Delivers completed words through a level valid/ack handshake with frame-error and overrun flags.
module serial_receiver
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Din,
    input  logic                  RxAck,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  RxValid,
    output logic                  RxBusy,
    output logic                  FrameErr,
    output logic                  Overrun
);

    localparam int HALF  = half_period(CLKS_PER_BIT);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(DATA_WIDTH - 1);

    logic                  din_s;
    rx_state_e             state_r;
    rx_state_e             state_next_s;
    logic [CNT_W-1:0]      clk_cnt_r;
    logic [CNT_W-1:0]      clk_cnt_next_s;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [BIT_W-1:0]      bit_cnt_next_s;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] shift_next_s;
    logic                  load_s;
    logic                  frame_err_s;

    // Inserts the newest received bit according to the link's bit order.
    function automatic logic [DATA_WIDTH-1:0] shift_in(
        input logic [DATA_WIDTH-1:0] cur,
        input logic                  bit_in
    );
        logic [DATA_WIDTH-1:0] res;
        if (MSB_FIRST) begin
            res = {cur[DATA_WIDTH-2:0], bit_in};
        end else begin
            res = {bit_in, cur[DATA_WIDTH-1:1]};
        end
        return res;
    endfunction

    bit_sync #(
        .RESET_VAL (LINE_IDLE)
    ) u_din_sync (
        .clk (Clk),
        .rst (Reset),
        .d   (Din),
        .q   (din_s)
    );

    // Next-state, counter and shift-register logic for the frame FSM.
    always_comb begin
        state_next_s   = state_r;
        clk_cnt_next_s = clk_cnt_r;
        bit_cnt_next_s = bit_cnt_r;
        shift_next_s   = shift_r;
        load_s         = 1'b0;
        frame_err_s    = 1'b0;

        case (state_r)
            IDLE: begin
                clk_cnt_next_s = {CNT_W{1'b0}};
                if (din_s == START_BIT) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end

            START: begin
                if (clk_cnt_r == HALF_LAST) begin
                    clk_cnt_next_s = {CNT_W{1'b0}};
                    bit_cnt_next_s = {BIT_W{1'b0}};
                    // A start bit that is gone by mid-bit is treated as line noise.
                    if (din_s == START_BIT) begin
                        state_next_s = DATA;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + CNT_W'(1);
                end
            end

            DATA: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_next_s = {CNT_W{1'b0}};
                    shift_next_s   = shift_in(shift_r, din_s);
                    if (bit_cnt_r == WORD_LAST) begin
                        bit_cnt_next_s = {BIT_W{1'b0}};
                        state_next_s   = STOP;
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + BIT_W'(1);
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + CNT_W'(1);
                end
            end

            STOP: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_next_s = {CNT_W{1'b0}};
                    state_next_s   = IDLE;
                    if (din_s == STOP_BIT) begin
                        load_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + CNT_W'(1);
                end
            end

            default: begin
                state_next_s   = IDLE;
                clk_cnt_next_s = {CNT_W{1'b0}};
                bit_cnt_next_s = {BIT_W{1'b0}};
            end
        endcase
    end

    // FSM state, counters and shift register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r   <= IDLE;
            clk_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
            shift_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r   <= state_next_s;
            clk_cnt_r <= clk_cnt_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            shift_r   <= shift_next_s;
        end
    end

    // Registered status outputs; RxBusy mirrors the state register exactly.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RxBusy   <= 1'b0;
            FrameErr <= 1'b0;
        end else begin
            RxBusy   <= (state_next_s != IDLE);
            FrameErr <= frame_err_s;
        end
    end

    // Word handoff: a new word always wins; an ack in the same cycle suppresses overrun.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            DataOut <= {DATA_WIDTH{1'b0}};
            RxValid <= 1'b0;
            Overrun <= 1'b0;
        end else if (load_s) begin
            DataOut <= shift_r;
            RxValid <= 1'b1;
            if (RxValid && !RxAck) begin
                Overrun <= 1'b1;
            end else if (RxAck) begin
                Overrun <= 1'b0;
            end else begin
                Overrun <= Overrun;
            end
        end else if (RxAck && RxValid) begin
            RxValid <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            RxValid <= RxValid;
            Overrun <= Overrun;
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver: frames are modelled at frame level (word, stop bit, start time)
// and a separate monitor compares every word/frame-error event the receiver reports.
module tb_serial_receiver;

    localparam int DW   = 32;
    localparam int CPB  = 2;
    localparam int HALF = CPB / 2;
    // Cycles from driving the start bit to the event being visible at the following negedge.
    localparam longint LAT = 1 + 2 + HALF + (DW + 1) * CPB;

    typedef struct {
        bit          err;
        logic [31:0] data;
        longint      start;
    } ev_t;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Din;
    logic          RxAck = 1'b0;
    logic [DW-1:0] DataOut;
    logic          RxValid;
    logic          RxBusy;
    logic          FrameErr;
    logic          Overrun;

    ev_t    exp_q[$];
    int     total = 0;
    int     passed = 0;
    longint cyc = 0;
    bit     auto_ack = 1'b0;
    bit     man_ack = 1'b0;
    logic   valid_prev = 1'b0;
    logic [31:0] last_good = 32'h0;

    serial_receiver #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Din      (Din),
        .RxAck    (RxAck),
        .DataOut  (DataOut),
        .RxValid  (RxValid),
        .RxBusy   (RxBusy),
        .FrameErr (FrameErr),
        .Overrun  (Overrun)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Ack driver: in auto mode acknowledges every word as soon as it is seen.
    initial begin
        forever begin
            @(negedge Clk);
            RxAck = auto_ack ? RxValid : man_ack;
        end
    end

    // Monitor: every new word or frame error must match the oldest expected event.
    always @(negedge Clk) begin
        ev_t e;
        if (!Reset && ((RxValid && !valid_prev) || FrameErr)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", 64'(FrameErr), 64'(e.err));
                if (!e.err) begin
                    check("word", 64'(DataOut), 64'(e.data));
                    check("overrun_on_word", 64'(Overrun), 64'd0);
                end
                check("latency", 64'(cyc - e.start), 64'(LAT));
            end
        end
        valid_prev <= RxValid;
    end

    // Drives the first n bits of a frame (start, data MSB-first, stop), then returns the line to idle.
    task automatic send_bits(input logic [31:0] data, input logic stop, input int n, input bit expect_ev);
        logic [DW+1:0] bits;
        ev_t e;
        bits = {1'b0, data, stop};
        if (expect_ev) begin
            e.err = !stop;
            e.data = data;
            e.start = cyc;
            exp_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            Din = bits[DW + 1 - i];
            repeat (CPB) @(posedge Clk);
            #1;
        end
        Din = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] data, input logic stop, input bit expect_ev);
        send_bits(data, stop, DW + 2, expect_ev);
        if (stop && expect_ev) last_good = data;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge Clk);
        repeat (3) @(posedge Clk);
        #1;
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_busy;
        logic [31:0] d;
        logic s;
        int gap;

        Reset = 1'b1;
        Din = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_dataout", 64'(DataOut), 64'd0);
        check("reset_valid", 64'(RxValid), 64'd0);
        check("reset_busy", 64'(RxBusy), 64'd0);
        check("reset_frameerr", 64'(FrameErr), 64'd0);
        check("reset_overrun", 64'(Overrun), 64'd0);
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;

        // Basic frame.
        auto_ack = 1'b1;
        send_frame(32'h12345678, 1'b1, 1'b1);
        drain();
        check("t1_dataout", 64'(DataOut), 64'(last_good));
        check("t1_overrun", 64'(Overrun), 64'd0);

        // One-cycle glitch on an idle line.
        saw_busy = 1'b0;
        Din = 1'b0;
        @(posedge Clk);
        #1;
        Din = 1'b1;
        repeat (HALF + 3) begin
            @(negedge Clk);
            if (RxBusy) saw_busy = 1'b1;
        end
        check("glitch_busy_seen", 64'(saw_busy), 64'd1);
        check("glitch_busy_cleared", 64'(RxBusy), 64'd0);
        repeat (4) @(posedge Clk);
        #1;

        // Bad stop bit.
        send_frame(32'hA5A5A5A5, 1'b0, 1'b1);
        drain();
        check("t3_dataout_kept", 64'(DataOut), 64'(last_good));
        check("t3_valid", 64'(RxValid), 64'd0);

        // Back-to-back words without ack.
        auto_ack = 1'b0;
        send_frame(32'h00000001, 1'b1, 1'b1);
        send_frame(32'hFFFFFFFF, 1'b1, 1'b0);
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        check("t4_dataout", 64'(DataOut), 64'hFFFFFFFF);
        check("t4_valid", 64'(RxValid), 64'd1);
        check("t4_overrun", 64'(Overrun), 64'd1);
        @(posedge Clk);
        #1;
        man_ack = 1'b1;
        @(posedge Clk);
        #1;
        man_ack = 1'b0;
        @(negedge Clk);
        check("t4_ack_valid", 64'(RxValid), 64'd0);
        check("t4_ack_overrun", 64'(Overrun), 64'd0);
        drain();

        // Reset in the middle of a frame while a word is pending.
        send_frame(32'hCAFEF00D, 1'b1, 1'b1);
        repeat (4) @(posedge Clk);
        #1;
        send_bits(32'h13579BDF, 1'b1, 17, 1'b0);
        check("t5_busy_midframe", 64'(RxBusy), 64'd1);
        Reset = 1'b1;
        #1;
        check("t5_reset_dataout", 64'(DataOut), 64'd0);
        check("t5_reset_valid", 64'(RxValid), 64'd0);
        check("t5_reset_busy", 64'(RxBusy), 64'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        auto_ack = 1'b1;
        @(posedge Clk);
        #1;
        send_frame(32'hDEADBEEF, 1'b1, 1'b1);
        drain();
        check("t5_dataout", 64'(DataOut), 64'hDEADBEEF);

        // Line stuck low for two frame times: two frame errors, then idle.
        send_frame(32'h0, 1'b0, 1'b1);
        send_frame(32'h0, 1'b0, 1'b1);
        drain();
        check("stuck_busy", 64'(RxBusy), 64'd0);

        // Randomised frames, gaps and stop bits.
        for (int k = 0; k < 30; k++) begin
            d = $urandom;
            if (k == 0) d = 32'h00000000;
            if (k == 1) d = 32'hFFFFFFFF;
            s = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(0, 3);
            send_frame(d, s, 1'b1);
            repeat (gap) @(posedge Clk);
            #1;
        end
        drain();
        check("final_dataout", 64'(DataOut), 64'(last_good));
        check("final_valid", 64'(RxValid), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
